// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch stage in front of the instruction ROM.
// Presents the PC to the ROM, captures the combinational ROM word into the
// fetch/decode register, and handles Start/Ack, branches with flush, stalls
// and the all-ones halt instruction.
module fetch_unit #(
  parameter int                 ADDR_W     = 11,
  parameter int                 INST_W     = 9,
  parameter int                 OFS_W      = 8,
  parameter logic [ADDR_W-1:0]  START_ADDR = {ADDR_W{1'b0}},
  parameter logic [INST_W-1:0]  HALT_INST  = 9'h1FF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stall,
  input  logic              BranchAbs,
  input  logic              BranchRel,
  input  logic [ADDR_W-1:0] Target,
  input  logic [OFS_W-1:0]  Offset,
  input  logic [INST_W-1:0] InstIn,
  output logic [ADDR_W-1:0] InstAddress,
  output logic [INST_W-1:0] InstReg,
  output logic [ADDR_W-1:0] InstRegAddr,
  output logic              InstValid,
  output logic              Ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t              state_r,     state_s;
  logic [ADDR_W-1:0]   pc_r,        pc_s;
  logic [INST_W-1:0]   inst_reg_r,  inst_reg_s;
  logic [ADDR_W-1:0]   inst_addr_r, inst_addr_s;
  logic                valid_r,     valid_s;
  logic                ack_r,       ack_s;
  logic [ADDR_W-1:0]   rel_target_s;
  logic [ADDR_W-1:0]   pc_inc_s;

  // Relative target is taken from the address of the instruction in InstReg,
  // with the offset sign-extended; the sum wraps modulo 2**ADDR_W.
  always_comb begin
    rel_target_s = inst_addr_r + {{(ADDR_W-OFS_W){Offset[OFS_W-1]}}, Offset};
    pc_inc_s     = pc_r + ADDR_W'(1'b1);
  end

  // Next-state and next-register computation; every register holds unless a rule moves it.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    inst_reg_s  = inst_reg_r;
    inst_addr_s = inst_addr_r;
    valid_s     = valid_r;
    ack_s       = ack_r;
    case (state_r)
      ST_IDLE: begin
        valid_s = 1'b0;
        ack_s   = 1'b0;
        if (Start) begin
          state_s = ST_RUN;
          pc_s    = START_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (BranchAbs) begin
          // Flush the wrong-path fetch; InstReg keeps its last word.
          pc_s    = Target;
          valid_s = 1'b0;
        end else if (BranchRel) begin
          pc_s    = rel_target_s;
          valid_s = 1'b0;
        end else if (Stall) begin
          pc_s    = pc_r;
        end else if (InstIn == HALT_INST) begin
          // Deliver the halt word once, then park the PC on it.
          inst_reg_s  = InstIn;
          inst_addr_s = pc_r;
          valid_s     = 1'b1;
          state_s     = ST_HALT;
        end else begin
          inst_reg_s  = InstIn;
          inst_addr_s = pc_r;
          valid_s     = 1'b1;
          pc_s        = pc_inc_s;
        end
      end
      ST_HALT: begin
        if (Start) begin
          state_s = ST_RUN;
          pc_s    = START_ADDR;
          ack_s   = 1'b0;
          valid_s = 1'b0;
        end else begin
          valid_s = 1'b0;
          ack_s   = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = START_ADDR;
        valid_s = 1'b0;
        ack_s   = 1'b0;
      end
    endcase
  end

  // State and pipeline registers; asynchronous reset clears everything at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_IDLE;
      pc_r        <= START_ADDR;
      inst_reg_r  <= {INST_W{1'b0}};
      inst_addr_r <= {ADDR_W{1'b0}};
      valid_r     <= 1'b0;
      ack_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      inst_reg_r  <= inst_reg_s;
      inst_addr_r <= inst_addr_s;
      valid_r     <= valid_s;
      ack_r       <= ack_s;
    end
  end

  // Outputs come straight from registers; no input reaches them combinationally.
  always_comb begin
    InstAddress = pc_r;
    InstReg     = inst_reg_r;
    InstRegAddr = inst_addr_r;
    InstValid   = valid_r;
    Ack         = ack_r;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus against a behavioural model
// of the fetch stage, with a ROM array inside the bench feeding InstIn.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        babs = 1'b0;
  logic        brel = 1'b0;
  logic [10:0] target = 11'h000;
  logic [7:0]  offset = 8'h00;
  logic [8:0]  inst_in;
  logic [10:0] inst_address;
  logic [8:0]  inst_reg;
  logic [10:0] inst_reg_addr;
  logic        inst_valid;
  logic        ack;

  logic [8:0]  rom [0:2047];

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: mode 0 idle, 1 running, 2 halted
  int          m_mode;
  logic [10:0] m_pc;
  logic [10:0] m_ia;
  logic [8:0]  m_ir;
  logic        m_v;
  logic        m_ack;

  fetch_unit dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .Start       (start),
    .Stall       (stall),
    .BranchAbs   (babs),
    .BranchRel   (brel),
    .Target      (target),
    .Offset      (offset),
    .InstIn      (inst_in),
    .InstAddress (inst_address),
    .InstReg     (inst_reg),
    .InstRegAddr (inst_reg_addr),
    .InstValid   (inst_valid),
    .Ack         (ack)
  );

  assign inst_in = rom[inst_address];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rom_fill(input int halts);
    for (int i = 0; i < 2048; i++) rom[i] = 9'($urandom_range(0, 510));
    for (int i = 0; i < halts; i++) rom[$urandom_range(0, 2047)] = 9'h1FF;
  endtask

  // Model update: one program step per rising edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 11'h000; m_ia = 11'h000; m_ir = 9'h000; m_v = 1'b0; m_ack = 1'b0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_pc = 11'h000; end
    end else if (m_mode == 1) begin
      if (babs) begin
        m_pc = target; m_v = 1'b0;
      end else if (brel) begin
        m_pc = 11'((int'(m_ia) + int'($signed(offset))) & 32'h7FF); m_v = 1'b0;
      end else if (!stall) begin
        m_ir = rom[m_pc]; m_ia = m_pc; m_v = 1'b1;
        if (m_ir == 9'h1FF) m_mode = 2;
        else m_pc = 11'((int'(m_pc) + 1) % 2048);
      end
    end else begin
      if (start) begin m_mode = 1; m_pc = 11'h000; m_ack = 1'b0; m_v = 1'b0; end
      else begin m_v = 1'b0; m_ack = 1'b1; end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pc",    32'(inst_address),  32'(m_pc));
      chk("m_valid", 32'(inst_valid),    32'(m_v));
      chk("m_ack",   32'(ack),           32'(m_ack));
      if (m_v) begin
        chk("m_ir", 32'(inst_reg),      32'(m_ir));
        chk("m_ia", 32'(inst_reg_addr), 32'(m_ia));
      end
    end
  end

  task automatic async_reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc",  32'(inst_address),  32'h000);
    chk("rst_ir",  32'(inst_reg),      32'h000);
    chk("rst_ia",  32'(inst_reg_addr), 32'h000);
    chk("rst_v",   32'(inst_valid),    32'h0);
    chk("rst_ack", 32'(ack),           32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] exp_seq [4];
    exp_seq[0] = 9'h001; exp_seq[1] = 9'h002; exp_seq[2] = 9'h003; exp_seq[3] = 9'h1FF;
    rom_fill(0);
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h1FF;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_pc",  32'(inst_address),  32'h000);
    chk("reset_ir",  32'(inst_reg),      32'h000);
    chk("reset_ia",  32'(inst_reg_addr), 32'h000);
    chk("reset_v",   32'(inst_valid),    32'h0);
    chk("reset_ack", 32'(ack),           32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Short program ending in halt
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_pc", 32'(inst_address), 32'h000);
    chk("start_v",  32'(inst_valid),   32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("seq_ir", 32'(inst_reg),      32'(exp_seq[k]));
      chk("seq_ia", 32'(inst_reg_addr), 32'(k));
      chk("seq_v",  32'(inst_valid),    32'h1);
    end
    chk("halt_ack0", 32'(ack), 32'h0);
    @(negedge clk);
    chk("halt_ack1", 32'(ack),          32'h1);
    chk("halt_v0",   32'(inst_valid),   32'h0);
    chk("halt_pc",   32'(inst_address), 32'h003);
    @(negedge clk);
    chk("halt_pc2",  32'(inst_address), 32'h003);

    // Restart from halt; Start during run must not disturb the PC
    rom[3] = 9'h004;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart_ack", 32'(ack),          32'h0);
    chk("restart_pc",  32'(inst_address), 32'h000);
    @(negedge clk);
    chk("restart_ir", 32'(inst_reg),     32'h001);
    chk("restart_pc1", 32'(inst_address), 32'h001);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("run_start_pc", 32'(inst_address), 32'h002);
    repeat (3) @(negedge clk);
    chk("pc5", 32'(inst_address), 32'h005);

    // Absolute branch with one bubble
    babs = 1'b1; target = 11'h040;
    @(negedge clk) babs = 1'b0;
    chk("babs_v",  32'(inst_valid),   32'h0);
    chk("babs_pc", 32'(inst_address), 32'h040);
    @(negedge clk);
    chk("babs_ia", 32'(inst_reg_addr), 32'h040);
    chk("babs_ir", 32'(inst_reg),      32'(rom[11'h040]));
    chk("babs_v1", 32'(inst_valid),    32'h1);

    // Relative branch backwards across zero
    babs = 1'b1; target = 11'h002;
    @(negedge clk) babs = 1'b0;
    @(negedge clk);
    chk("rel_prep_ia", 32'(inst_reg_addr), 32'h002);
    brel = 1'b1; offset = 8'hFD;
    @(negedge clk) brel = 1'b0;
    chk("brel_pc", 32'(inst_address), 32'h7FF);
    chk("brel_v",  32'(inst_valid),   32'h0);
    @(negedge clk);
    chk("wrap_ia", 32'(inst_reg_addr), 32'h7FF);
    chk("wrap_pc", 32'(inst_address),  32'h000);

    // Stall holds everything; branch beats stall
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_pc", 32'(inst_address),  32'h000);
      chk("stall_ia", 32'(inst_reg_addr), 32'h7FF);
      chk("stall_v",  32'(inst_valid),    32'h1);
    end
    babs = 1'b1; target = 11'h010;
    @(negedge clk) begin babs = 1'b0; stall = 1'b0; end
    chk("stall_babs_pc", 32'(inst_address), 32'h010);
    chk("stall_babs_v",  32'(inst_valid),   32'h0);

    // Asynchronous reset mid-run, then no fetch without Start
    async_reset_pulse();
    repeat (3) begin
      @(negedge clk);
      chk("idle_pc", 32'(inst_address), 32'h000);
      chk("idle_v",  32'(inst_valid),   32'h0);
    end

    // Randomized phase
    rom_fill(12);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 15) == 0);
      babs   = ($urandom_range(0, 19) == 0);
      brel   = ($urandom_range(0, 19) == 0);
      stall  = ($urandom_range(0, 5) == 0);
      target = 11'($urandom);
      offset = 8'($urandom);
      if ($urandom_range(0, 499) == 0) async_reset_pulse();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
